// File: rtl/fifo_pack_ctrl.sv
// fifo_pack_ctrl
// Narrow-to-wide FIFO: one DATA_WIDTH word is pushed per write, and two
// words are popped per read as a 2*DATA_WIDTH pair. It sits between a
// byte-serial producer and a word-parallel consumer. It holds its own
// register-file storage plus the pointer and occupancy control.
//
// Ports
//   clk        clock, all state updates on posedge
//   reset      synchronous, active-high reset (overrides rd/wr)
//   wr_i       push w_data_i as one entry
//   w_data_i   write data, DATA_WIDTH bits
//   rd_i       pop one pair (two entries)
//   r_data_o   show-ahead pair {older, newer}; don't-care while empty_o=1
//   empty_o    fewer than two entries stored
//   full_o     DEPTH entries stored
//   count_o    stored entries, 0..DEPTH
//   overflow_o / underflow_o   sticky rejected-write / rejected-read flags,
//              present only when FIFO_PACK_ERR_FLAGS_EN is defined
//
// Optional feature macro: FIFO_PACK_ERR_FLAGS_EN

module fifo_pack_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    wr_i,
    input  logic [DATA_WIDTH-1:0]   w_data_i,
    input  logic                    rd_i,
    output logic [2*DATA_WIDTH-1:0] r_data_o,
    output logic                    empty_o,
    output logic                    full_o,
`ifdef FIFO_PACK_ERR_FLAGS_EN
    output logic                    overflow_o,
    output logic                    underflow_o,
`endif
    output logic [ADDR_WIDTH:0]     count_o
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    localparam logic [ADDR_WIDTH:0]   DEPTH_C  = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0]   PAIR_C   = (ADDR_WIDTH+1)'(2);
    localparam logic [ADDR_WIDTH-1:0] PTR_INC1 = ADDR_WIDTH'(1);
    // With ADDR_WIDTH=1 this truncates to 0, which is still +2 mod DEPTH.
    localparam logic [ADDR_WIDTH-1:0] PTR_INC2 = ADDR_WIDTH'(2);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_addr_newer;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic [ADDR_WIDTH+1:0] count_ext;
    logic                  count_unused;
    logic                  rd_ok;
    logic                  wr_ok;

    always_comb begin
        rd_ok = rd_i & (count_q >= PAIR_C);
        // A full FIFO still takes a write when a pair leaves in the same cycle.
        wr_ok = wr_i & ((count_q < DEPTH_C) | rd_ok);

        rd_ptr_d = rd_ok ? (rd_ptr_q + PTR_INC2) : rd_ptr_q;
        wr_ptr_d = wr_ok ? (wr_ptr_q + PTR_INC1) : wr_ptr_q;

        // One bit of headroom so the intermediate add/subtract cannot alias.
        count_ext = {1'b0, count_q}
                  + {{(ADDR_WIDTH+1){1'b0}}, wr_ok}
                  - {{ADDR_WIDTH{1'b0}}, rd_ok, 1'b0};
        count_d   = count_ext[ADDR_WIDTH:0];
    end

    // The top bit is always zero for legal occupancies.
    assign count_unused = count_ext[ADDR_WIDTH+1];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is deliberately not reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (!reset && wr_ok) begin
            mem_q[wr_ptr_q] <= w_data_i;
        end
    end

    assign rd_addr_newer = rd_ptr_q + PTR_INC1;
    assign r_data_o      = {mem_q[rd_ptr_q], mem_q[rd_addr_newer]};
    assign empty_o       = (count_q < PAIR_C);
    assign full_o        = (count_q == DEPTH_C);
    assign count_o       = count_q;

`ifdef FIFO_PACK_ERR_FLAGS_EN
    logic overflow_q, overflow_d;
    logic underflow_q, underflow_d;

    always_comb begin
        overflow_d  = overflow_q  | (wr_i & ~wr_ok);
        underflow_d = underflow_q | (rd_i & ~rd_ok);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign overflow_o  = overflow_q;
    assign underflow_o = underflow_q;
`endif

endmodule

// File: tb/tb_fifo_pack_ctrl.sv
// Testbench for fifo_pack_ctrl (DATA_WIDTH=8, ADDR_WIDTH=3, DEPTH=8).
// The reference is a byte queue: writes append, reads remove the two
// oldest bytes, and acceptance is decided from the queue size alone.

module tb_fifo_pack_ctrl;

    localparam int DW    = 8;
    localparam int AW    = 3;
    localparam int DEPTH = 8;

    logic            clk;
    logic            reset;
    logic            wr;
    logic [DW-1:0]   w_data;
    logic            rd;
    logic [2*DW-1:0] r_data;
    logic            empty;
    logic            full;
    logic [AW:0]     count;
`ifdef FIFO_PACK_ERR_FLAGS_EN
    logic            overflow;
    logic            underflow;
`endif

    fifo_pack_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk        (clk),
        .reset      (reset),
        .wr_i       (wr),
        .w_data_i   (w_data),
        .rd_i       (rd),
        .r_data_o   (r_data),
        .empty_o    (empty),
        .full_o     (full),
`ifdef FIFO_PACK_ERR_FLAGS_EN
        .overflow_o (overflow),
        .underflow_o(underflow),
`endif
        .count_o    (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] q[$];
    logic          ovf_m = 1'b0;
    logic          unf_m = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Compare every observable output against the model's current contents.
    task automatic check_state();
        check("count", 32'(count), 32'(q.size()));
        check("empty", 32'(empty), 32'(q.size() < 2));
        check("full", 32'(full), 32'(q.size() == DEPTH));
        check("count_le_depth", 32'(count <= DEPTH), 32'd1);
        if (q.size() >= 2) check("r_data", 32'(r_data), {16'h0, q[0], q[1]});
`ifdef FIFO_PACK_ERR_FLAGS_EN
        check("overflow", 32'(overflow), 32'(ovf_m));
        check("underflow", 32'(underflow), 32'(unf_m));
`endif
    endtask

    task automatic drive(input logic w, input logic [DW-1:0] d, input logic r);
        wr = w;
        w_data = d;
        rd = r;
        #1;
        check_state();
    endtask

    task automatic tick();
        bit r_ok, w_ok;
        @(posedge clk);
        if (reset) begin
            q.delete();
            ovf_m = 1'b0;
            unf_m = 1'b0;
        end else begin
            r_ok = rd && (q.size() >= 2);
            w_ok = wr && ((q.size() < DEPTH) || r_ok);
            if (rd && !r_ok) unf_m = 1'b1;
            if (wr && !w_ok) ovf_m = 1'b1;
            if (r_ok) begin
                void'(q.pop_front());
                void'(q.pop_front());
            end
            if (w_ok) q.push_back(w_data);
        end
        @(negedge clk);
    endtask

    task automatic step(input logic w, input logic [DW-1:0] d, input logic r);
        drive(w, d, r);
        tick();
    endtask

    task automatic apply_reset(input logic w, input int cycles);
        reset = 1'b1;
        wr = w;
        w_data = DW'($urandom);
        rd = 1'b0;
        repeat (cycles) tick();
        reset = 1'b0;
        drive(1'b0, '0, 1'b0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full", 32'(full), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int j, k;
        reset = 1'b1;
        wr = 1'b0;
        rd = 1'b0;
        w_data = '0;
        @(negedge clk);

        // Reset, plain and with a write pending
        apply_reset(1'b0, 2);
        apply_reset(1'b1, 2);

        // Basic pair
        step(1'b1, 8'hA1, 1'b0);
        drive(1'b0, '0, 1'b0);
        check("one_entry_empty", 32'(empty), 32'd1);
        step(1'b1, 8'hB2, 1'b0);
        drive(1'b0, '0, 1'b0);
        check("pair_empty", 32'(empty), 32'd0);
        check("pair_count", 32'(count), 32'd2);
        check("pair_rdata", 32'(r_data), 32'h0000A1B2);
        step(1'b0, '0, 1'b1);
        drive(1'b0, '0, 1'b0);
        check("after_rd_count", 32'(count), 32'd0);
        check("after_rd_empty", 32'(empty), 32'd1);

        // Read with a single entry is rejected
        step(1'b1, 8'h11, 1'b0);
        step(1'b0, '0, 1'b1);
        drive(1'b0, '0, 1'b0);
        check("underflow_count", 32'(count), 32'd1);
        check("underflow_empty", 32'(empty), 32'd1);
`ifdef FIFO_PACK_ERR_FLAGS_EN
        check("underflow_flag", 32'(underflow), 32'd1);
`endif
        step(1'b1, 8'h22, 1'b0);
        drive(1'b0, '0, 1'b0);
        check("rdata_1122", 32'(r_data), 32'h00001122);
        step(1'b0, '0, 1'b1);

        // Full, rejected write, then simultaneous read+write at full
        for (int i = 1; i <= 8; i++) step(1'b1, DW'(i), 1'b0);
        drive(1'b0, '0, 1'b0);
        check("full_flag", 32'(full), 32'd1);
        check("full_count", 32'(count), 32'd8);
        step(1'b1, 8'h09, 1'b0);
        drive(1'b0, '0, 1'b0);
        check("ovf_count", 32'(count), 32'd8);
`ifdef FIFO_PACK_ERR_FLAGS_EN
        check("overflow_flag", 32'(overflow), 32'd1);
`endif
        drive(1'b1, 8'h09, 1'b1);
        check("rdwr_full_rdata", 32'(r_data), 32'h00000102);
        tick();
        drive(1'b0, '0, 1'b0);
        check("rdwr_full_count", 32'(count), 32'd7);
        check("rdwr_full_full", 32'(full), 32'd0);

        // Pointer wrap: 24 writes interleaved with 12 reads
        apply_reset(1'b0, 1);
        j = 0;
        k = 0;
        for (int i = 0; i < 6; i++) begin
            step(1'b1, DW'(j), 1'b0);
            j++;
        end
        for (int c = 0; c < 200 && k < 12; c++) begin
            logic dw, dr;
            dw = (j < 24);
            dr = ((c % 2) == 0 || j >= 24) && (q.size() >= 2);
            drive(dw, DW'(j), dr);
            if (dr) begin
                check("wrap_pair", 32'(r_data), {16'h0, 8'(2*k), 8'(2*k+1)});
                k++;
            end
            if (dw) j++;
            tick();
        end
        check("wrap_reads_done", 32'(k), 32'd12);

        // Randomized traffic with occasional reset
        for (int c = 0; c < 400; c++) begin
            reset = ($urandom_range(0, 63) == 0);
            step(($urandom_range(0, 99) < 55), DW'($urandom), ($urandom_range(0, 99) < 45));
        end
        reset = 1'b0;

        // Reset with data stored discards it; storage restarts at address 0
        apply_reset(1'b0, 1);
        for (int i = 0; i < 6; i++) step(1'b1, DW'($urandom), 1'b0);
        apply_reset(1'b0, 1);
        step(1'b1, 8'h5A, 1'b0);
        step(1'b1, 8'hC3, 1'b0);
        drive(1'b0, '0, 1'b0);
        check("post_reset_rdata", 32'(r_data), 32'h00005AC3);
        check("post_reset_count", 32'(count), 32'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
